// File: rtl/sat_ctr_pkg.sv
// Shared parameters, operation kinds and the saturating-counter update rule
// for the SRAM-backed counter table.
package sat_ctr_pkg;

    localparam int unsigned      DEPTH    = 512;
    localparam int unsigned      IDX_W    = 9;
    localparam int unsigned      CTR_W    = 2;
    localparam int unsigned      QDEPTH   = 4;
    localparam logic [CTR_W-1:0] CTR_INIT = 2'b01;

    typedef enum logic [1:0] {
        NONE,
        LOOKUP,
        UPDATE
    } op_kind_e;

    // Step the counter toward the branch direction, clamping at both ends.
    function automatic logic [CTR_W-1:0] sat(input logic [CTR_W-1:0] c, input logic taken);
        if (taken) begin
            return (c == '1) ? c : c + CTR_W'(1);
        end
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

endpackage

// File: rtl/sat_ctr_upd_fifo.sv
// Small synchronous FIFO holding pending counter updates ({idx, taken}).
module sat_ctr_upd_fifo #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned DATA_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [DATA_W-1:0] mem_q [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign full_o      = (cnt_q == CNT_W'(QDEPTH));
    assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/sat_ctr_sram_ctrl.sv
// Saturating-counter table controller: initialises an external 1R1W SRAM, then
// serves lookups and queued read-modify-write updates through a two-stage pipe.
module sat_ctr_sram_ctrl #(
    parameter int unsigned      DEPTH    = sat_ctr_pkg::DEPTH,
    parameter int unsigned      IDX_W    = sat_ctr_pkg::IDX_W,
    parameter int unsigned      CTR_W    = sat_ctr_pkg::CTR_W,
    parameter int unsigned      QDEPTH   = sat_ctr_pkg::QDEPTH,
    parameter logic [CTR_W-1:0] CTR_INIT = sat_ctr_pkg::CTR_INIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             resp_valid,
    output logic [CTR_W-1:0] resp_ctr,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             init_done,
    output logic             sram_web,
    output logic [IDX_W-1:0] sram_aa,
    output logic [CTR_W-1:0] sram_d,
    output logic             sram_reb,
    output logic [IDX_W-1:0] sram_ab,
    input  logic [CTR_W-1:0] sram_q
);

    import sat_ctr_pkg::*;

    logic             init_done_q, init_done_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    op_kind_e         s1_kind_q, s1_kind_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic             s1_taken_q, s1_taken_d;
    logic             fwd_en_q;
    logic [IDX_W-1:0] fwd_addr_q;
    logic [CTR_W-1:0] fwd_data_q;
    logic [CTR_W-1:0] s1_val;

    logic             q_push, q_pop, q_full, q_empty;
    logic [IDX_W-1:0] q_head_idx;
    logic             q_head_taken;

    sat_ctr_upd_fifo #(
        .QDEPTH (QDEPTH),
        .DATA_W (IDX_W + 1)
    ) u_upd_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (q_push),
        .push_data_i ({upd_idx, upd_taken}),
        .pop_i       (q_pop),
        .head_data_o ({q_head_idx, q_head_taken}),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    assign init_done = init_done_q;

    always_comb begin
        init_done_d = init_done_q;
        init_cnt_d  = init_cnt_q;
        s1_kind_d   = NONE;
        s1_idx_d    = '0;
        s1_taken_d  = 1'b0;
        rd_ready    = 1'b0;
        upd_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_ctr    = '0;
        sram_web    = 1'b1;
        sram_aa     = '0;
        sram_d      = '0;
        sram_reb    = 1'b1;
        sram_ab     = '0;
        q_pop       = 1'b0;
        // The SRAM hands back pre-write data when read and written in the same cycle.
        s1_val      = (fwd_en_q && (fwd_addr_q == s1_idx_q)) ? fwd_data_q : sram_q;

        // Reset is synchronous, so every outputs stays quiet during the reset cycle itself.
        if (!reset) begin
            if (!init_done_q) begin
                sram_web   = 1'b0;
                sram_aa    = init_cnt_q;
                sram_d     = CTR_INIT;
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                    init_done_d = 1'b1;
                end
            end else begin
                rd_ready  = !q_full;
                upd_ready = !q_full;

                if (q_full || (!rd_valid && !q_empty)) begin
                    q_pop      = 1'b1;
                    sram_reb   = 1'b0;
                    sram_ab    = q_head_idx;
                    s1_kind_d  = UPDATE;
                    s1_idx_d   = q_head_idx;
                    s1_taken_d = q_head_taken;
                end else if (rd_valid) begin
                    sram_reb  = 1'b0;
                    sram_ab   = rd_idx;
                    s1_kind_d = LOOKUP;
                    s1_idx_d  = rd_idx;
                end

                case (s1_kind_q)
                    LOOKUP: begin
                        resp_valid = 1'b1;
                        resp_ctr   = s1_val;
                    end
                    UPDATE: begin
                        sram_web = 1'b0;
                        sram_aa  = s1_idx_q;
                        sram_d   = sat(s1_val, s1_taken_q);
                    end
                    default: ;
                endcase
            end
        end

        q_push = upd_valid && upd_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            init_done_q <= 1'b0;
            init_cnt_q  <= '0;
            s1_kind_q   <= NONE;
            s1_idx_q    <= '0;
            s1_taken_q  <= 1'b0;
            fwd_en_q    <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            init_done_q <= init_done_d;
            init_cnt_q  <= init_cnt_d;
            s1_kind_q   <= s1_kind_d;
            s1_idx_q    <= s1_idx_d;
            s1_taken_q  <= s1_taken_d;
            fwd_en_q    <= ~sram_web;
            fwd_addr_q  <= sram_aa;
            fwd_data_q  <= sram_d;
        end
    end

endmodule
